prefetch_fetcher: RTL and testbench
===================================

# prefetch_fetcher

AXI4 read-master engine that services the prefetch buffer's refill requests. On each `prefetch_req` it issues one INCR read burst over the node array at `base_addr` and streams the returned beats into the buffer's `prefetch_data` valid/ready port through a one-entry output register. It tracks progress against `total_nodes` and reports completion and AXI errors to the BFS controller.

## Interface
- `DATA_WIDTH`, 32: beat and node width in bits; must be 32 or 64.
- `ADDR_WIDTH`, 32: AXI address width.
- `BURST_LEN`, 16: maximum beats per burst, 1..256.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that latches `base_addr`/`total_nodes`; ignored while `busy`.
- `base_addr` in ADDR_WIDTH: byte address of node 0; must be aligned to DATA_WIDTH/8.
- `total_nodes` in 16: number of nodes to fetch.
- `busy` out 1: a run is active.
- `done` out 1: one-cycle pulse when the run completes.
- `error` out 1: sticky error flag; cleared by `start` or `rst`.
- `prefetch_req` in 1: buffer requests a refill.
- `prefetch_grant` out 1: one-cycle pulse when a burst is committed.
- `prefetch_data` out DATA_WIDTH: node word.
- `prefetch_data_valid` out 1: `prefetch_data` is valid.
- `prefetch_data_ready` in 1: buffer accepts the word.
- `m_axi_araddr` out ADDR_WIDTH, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AR channel.
- `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: R channel.

## Operation
- FSM states: IDLE → ADDR → DATA → (IDLE | DONE).
  - IDLE: if `busy`, `prefetch_req`=1 and `issued < total` → ADDR.
  - ADDR: hold `arvalid` until `arready`.
  - DATA: accept beats until `rlast`.
  - DONE: lasts one cycle, then IDLE.
- `start` with `total_nodes`=0 → DONE directly.
- Constant AR fields:
  - `arsize` = log2(DATA_WIDTH/8).
  - `arburst` = INCR (2'b01).
  - `araddr` = `base + issued*(DATA_WIDTH/8)`, modulo 2^ADDR_WIDTH.
- Burst length: `beats` = min(BURST_LEN, `total - issued`, beats_to_4KB). `arlen` = `beats - 1`. `issued` (16-bit) advances by `beats` at the AR handshake.
- A committed burst always completes, even if `prefetch_req` deasserts.
- Output register:
  - `rready` = !`out_valid` || `prefetch_data_ready`.
  - An R beat loads `prefetch_data`.
  - `valid` stays high until consumed; a simultaneous drain and load keeps it high.
- Errors set the sticky `error` flag; the data is still forwarded:
  - `rresp` ≠ OKAY.
  - `rlast` on a beat other than the last.
  - `rlast` missing on the last beat.
- Run completion: after the last burst's final beat is accepted and `issued == total` → DONE. `done` pulses and `busy` drops in the same cycle. The final output word may still be pending in the output register.
- `rst` mid-run: all state clears immediately and in-flight AXI beats are abandoned. The system resets the interconnect together with this block.
- Reset values:
  - `busy`, `done`, `error` = 0.
  - `prefetch_grant`, `prefetch_data_valid`, `m_axi_arvalid` = 0.
  - `prefetch_data`, `m_axi_araddr`, `m_axi_arlen` = 0.
  - `m_axi_rready` = 1 (output register empty).

## Timing
- `start` sampled at edge T → `busy`=1 at T+1.
- Request sampled in IDLE at edge T → in cycle T+1: `arvalid`=1 and `prefetch_grant`=1 (grant lasts exactly one cycle).
- R beat accepted at edge N → `prefetch_data_valid`=1 at N+1.
- With a zero-wait slave, request-to-first-word latency is 3 cycles. Sustained throughput is 1 beat/cycle while `prefetch_data_ready`=1.
- No new AR is issued until the current burst's `rlast` is accepted: at most one burst outstanding.

## Configuration
- `PREFETCH_FETCHER_4K_SPLIT_EN` defined: bursts are clipped so they never cross a 4 KB boundary.
- Undefined: beats_to_4KB is treated as unlimited. Software must keep each burst within a 4 KB page.

## Structure
- Shared package `bfs_axi_pkg`:
  - AXI constants `AXI_BURST_INCR` and `AXI_RESP_OKAY`.
  - FSM state enum `pf_fetch_state_t`.
  - `NODE_BYTES` = DATA_WIDTH/8.
- One sub-module, `pf_out_reg`: the one-entry valid/ready output register.

## Test plan
- `base`=0x1000, `total`=40, `req` held high, BURST_LEN=16 → three ARs with `arlen` 15/15/7 at 0x1000/0x1040/0x1080. 40 words are delivered in order, followed by one `done` pulse.
- `base`=0x0FF8, `total`=8, macro defined → first AR `arlen`=1 at 0x0FF8, then `arlen`=5 at 0x1000. With the macro undefined → a single AR with `arlen`=7.
- `prefetch_data_ready` toggling 1/0 every cycle during a burst → no beat is dropped or duplicated, `rready` is low only while the register is full and stalled, and all 16 words match.
- `rresp`=SLVERR on beat 3 → `error`=1 and remains high after `done`. All beats are still forwarded. The next `start` clears `error`.
- `rst` asserted during DATA after 5 beats → next cycle `busy`=0, `arvalid`=0, `prefetch_data_valid`=0. A new `start` refetches from `base`.
- `total_nodes`=0 `start` → `done` at T+2, no AR is issued, and `prefetch_grant` never asserts.

Source files
------------

// File: rtl/bfs_axi_pkg.sv
// Shared definitions for the BFS prefetch AXI read path.
//   AXI_BURST_INCR / AXI_RESP_OKAY : AXI4 encodings used by the fetcher.
//   pf_fetch_state_t               : fetcher FSM states.
//   NODE_BYTES                     : bytes per node for the default 32-bit
//                                    node width; node_bytes() gives it for
//                                    any width.
package bfs_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned PF_DATA_WIDTH = 32;
  localparam int unsigned NODE_BYTES    = PF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_ADDR,
    PF_DATA,
    PF_DONE
  } pf_fetch_state_t;

  function automatic int unsigned node_bytes(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/prefetch_fetcher_if.sv
// AXI4 read-address and read-data channels between the prefetch fetcher
// (master) and the memory interconnect (slave).
//   AR: m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
//       m_axi_arvalid, m_axi_arready
//   R : m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, m_axi_rready
interface prefetch_fetcher_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/pf_out_reg.sv
// One-entry valid/ready output register.
//   in_valid/in_data/in_ready    : upstream (AXI R beat) side
//   out_valid/out_data/out_ready : downstream (prefetch buffer) side
// in_ready is high when empty or when the held word drains this cycle, so a
// simultaneous drain and load keeps out_valid high without a bubble.
module pf_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/prefetch_fetcher.sv
// AXI4 read-master that refills the prefetch buffer from the node array.
//   start/base_addr/total_nodes : begin a run (ignored while busy)
//   busy/done/error             : run status to the BFS controller
//   prefetch_req/prefetch_grant : refill request and burst-commit pulse
//   prefetch_data*              : node words through a one-entry register
//   m_axi                       : AXI4 read master (AR + R channels)
// Build option: PREFETCH_FETCHER_4K_SPLIT_EN clips bursts at 4 KB pages;
// without it software must keep each burst inside one page.
module prefetch_fetcher
  import bfs_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           total_nodes,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  prefetch_req,
  output logic                  prefetch_grant,
  output logic [DATA_WIDTH-1:0] prefetch_data,
  output logic                  prefetch_data_valid,
  input  logic                  prefetch_data_ready,
  prefetch_fetcher_if.master    m_axi
);

  localparam int unsigned NB   = node_bytes(DATA_WIDTH);
  localparam int unsigned SIZE = $clog2(NB);

  pf_fetch_state_t       state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           total_q, total_d;
  logic [15:0]           issued_q, issued_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  rready_w;
  logic                  beat_hs;
  logic                  last_beat;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [16:0]           beats;
`ifdef PREFETCH_FETCHER_4K_SPLIT_EN
  logic [12:0]           to_4k;
`endif

  assign beat_hs   = (state_q == PF_DATA) && m_axi.m_axi_rvalid && rready_w;
  assign last_beat = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    grant_d   = 1'b0;
    base_d    = base_q;
    total_d   = total_q;
    issued_d  = issued_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    cnt_d     = cnt_q;

    remaining = total_q - issued_q;
    cur_addr  = base_q + (ADDR_WIDTH'(issued_q) << SIZE);
    beats     = 17'(BURST_LEN);
    if ({1'b0, remaining} < beats) beats = {1'b0, remaining};
`ifdef PREFETCH_FETCHER_4K_SPLIT_EN
    to_4k = 13'(13'h1000 - {1'b0, cur_addr[11:0]}) >> SIZE;
    if (17'(to_4k) < beats) beats = 17'(to_4k);
`endif

    unique case (state_q)
      PF_IDLE: begin
        if (start && !busy_q) begin
          base_d   = base_addr;
          total_d  = total_nodes;
          issued_d = '0;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          if (total_nodes == '0) state_d = PF_DONE;
        end else if (busy_q && prefetch_req && (issued_q < total_q)) begin
          state_d   = PF_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = cur_addr;
          arlen_d   = 8'(beats - 17'd1);
          grant_d   = 1'b1;
        end
      end
      PF_ADDR: begin
        if (m_axi.m_axi_arready) begin
          arvalid_d = 1'b0;
          issued_d  = issued_q + 16'(arlen_q) + 16'd1;
          cnt_d     = arlen_q;
          state_d   = PF_DATA;
        end
      end
      PF_DATA: begin
        // Burst end is taken from the beat count, so a misplaced or missing
        // rlast is flagged but cannot desynchronise the engine.
        if (beat_hs) begin
          if ((m_axi.m_axi_rresp != AXI_RESP_OKAY) || (m_axi.m_axi_rlast != last_beat))
            error_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (last_beat) state_d = (issued_q == total_q) ? PF_DONE : PF_IDLE;
        end
      end
      PF_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = PF_IDLE;
      end
      default: state_d = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PF_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      grant_q   <= 1'b0;
      base_q    <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      grant_q   <= grant_d;
      base_q    <= base_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      cnt_q     <= cnt_d;
    end
  end

  pf_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_axi.m_axi_rvalid && (state_q == PF_DATA)),
    .in_data   (m_axi.m_axi_rdata),
    .in_ready  (rready_w),
    .out_valid (prefetch_data_valid),
    .out_data  (prefetch_data),
    .out_ready (prefetch_data_ready)
  );

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign prefetch_grant      = grant_q;
  assign m_axi.m_axi_araddr  = araddr_q;
  assign m_axi.m_axi_arlen   = arlen_q;
  assign m_axi.m_axi_arsize  = 3'(SIZE);
  assign m_axi.m_axi_arburst = AXI_BURST_INCR;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_w;

endmodule

// File: tb/tb_prefetch_fetcher.sv
module tb_prefetch_fetcher;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   total_nodes;
  logic          busy, done, error;
  logic          prefetch_req;
  logic          prefetch_grant;
  logic [DW-1:0] prefetch_data;
  logic          prefetch_data_valid;
  logic          prefetch_data_ready;

  always #5 clk = ~clk;

  prefetch_fetcher_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi_if ();

  prefetch_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .total_nodes         (total_nodes),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .prefetch_req        (prefetch_req),
    .prefetch_grant      (prefetch_grant),
    .prefetch_data       (prefetch_data),
    .prefetch_data_valid (prefetch_data_valid),
    .prefetch_data_ready (prefetch_data_ready),
    .m_axi               (axi_if.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         exp_ar_q[$];
  ar_t         burst_q[$];
  logic [31:0] exp_word_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int ar_count    = 0;
  int grant_count = 0;
  int done_count  = 0;
  int words_seen  = 0;
  int beats_sent  = 0;
  int err_beat    = -1;
  bit ready_toggle = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_word_q.push_back(mem_word(base + 32'(4 * i)));
  endtask

  // Zero-wait AXI slave: checks each AR against the expected list, then
  // returns the burst one beat per cycle.
  task automatic slave_loop();
    int          beat;
    bit          ar_hs, r_hs, rst_seen;
    logic [31:0] a_addr;
    logic [7:0]  a_len;
    ar_t         e;
    logic [31:0] a;
    beat = 0;
    forever begin
      @(negedge clk);
      ar_hs    = axi_if.m_axi_arvalid && axi_if.m_axi_arready;
      r_hs     = axi_if.m_axi_rvalid && axi_if.m_axi_rready;
      rst_seen = rst;
      a_addr   = axi_if.m_axi_araddr;
      a_len    = axi_if.m_axi_arlen;
      if (ar_hs && !rst_seen) begin
        vectors++;
        if ({axi_if.m_axi_arsize, axi_if.m_axi_arburst} !== {3'd2, 2'b01}) begin
          miscompares++;
          $display("FAIL ar_fields got size=%0d burst=%0d want size=2 burst=1",
                   axi_if.m_axi_arsize, axi_if.m_axi_arburst);
        end
        vectors++;
        if (burst_q.size() !== 0) begin
          miscompares++;
          $display("FAIL ar_outstanding got %0d bursts open want 0", burst_q.size());
        end
      end
      @(posedge clk);
      #1;
      if (rst_seen) begin
        burst_q.delete();
        beat = 0;
      end else begin
        if (ar_hs) begin
          ar_count++;
          vectors++;
          if (exp_ar_q.size() == 0) begin
            miscompares++;
            $display("FAIL ar_unexpected got addr=%h len=%0d want none", a_addr, a_len);
          end else begin
            e = exp_ar_q.pop_front();
            if ({a_addr, a_len} !== {e.addr, e.len}) begin
              miscompares++;
              $display("FAIL ar_addr_len got addr=%h len=%0d want addr=%h len=%0d",
                       a_addr, a_len, e.addr, e.len);
            end
          end
          burst_q.push_back('{addr: a_addr, len: a_len});
        end
        if (r_hs && burst_q.size() > 0) begin
          beats_sent++;
          beat++;
          if (beat > int'(burst_q[0].len)) begin
            void'(burst_q.pop_front());
            beat = 0;
          end
        end
      end
      if (burst_q.size() > 0) begin
        a = burst_q[0].addr + 32'(4 * beat);
        axi_if.m_axi_rvalid = 1'b1;
        axi_if.m_axi_rdata  = mem_word(a);
        axi_if.m_axi_rlast  = (beat == int'(burst_q[0].len));
        axi_if.m_axi_rresp  = (beats_sent == err_beat) ? 2'b10 : 2'b00;
      end else begin
        axi_if.m_axi_rvalid = 1'b0;
        axi_if.m_axi_rlast  = 1'b0;
        axi_if.m_axi_rresp  = 2'b00;
      end
    end
  endtask

  // Output-side scoreboard: pops one expected word per accepted transfer.
  task automatic consumer_loop();
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prefetch_data_valid && prefetch_data_ready) begin
          words_seen++;
          vectors++;
          if (exp_word_q.size() == 0) begin
            miscompares++;
            $display("FAIL word_unexpected got %h want none", prefetch_data);
          end else begin
            w = exp_word_q.pop_front();
            if (prefetch_data !== w) begin
              miscompares++;
              $display("FAIL word_data got %h want %h", prefetch_data, w);
            end
          end
        end
        if (!axi_if.m_axi_rready) begin
          vectors++;
          if ({prefetch_data_valid, prefetch_data_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rready_low got valid=%b ready=%b want valid=1 ready=0",
                     prefetch_data_valid, prefetch_data_ready);
          end
        end
        if (done) done_count++;
        if (prefetch_grant) grant_count++;
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) prefetch_data_ready = ~prefetch_data_ready;
      else prefetch_data_ready = 1'b1;
    end
  endtask

  task automatic wait_run(input string name, input int d0, input int max_cyc);
    int n = 0;
    while ((done_count == d0 || exp_word_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= max_cyc) begin
      miscompares++;
      $display("FAIL %s_timeout got done=%0d words_left=%0d want done and 0 left",
               name, done_count - d0, exp_word_q.size());
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    prefetch_req = 1'b0;
    base_addr = '0;
    total_nodes = '0;
    tick();
    tick();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_error", error, 1'b0);
    check_bit("rst_grant", prefetch_grant, 1'b0);
    check_bit("rst_valid", prefetch_data_valid, 1'b0);
    check_bit("rst_arvalid", axi_if.m_axi_arvalid, 1'b0);
    check_bit("rst_rready", axi_if.m_axi_rready, 1'b1);
    vectors++;
    if ({prefetch_data, axi_if.m_axi_araddr, axi_if.m_axi_arlen} !== 72'd0) begin
      miscompares++;
      $display("FAIL rst_regs got data=%h araddr=%h arlen=%h want 0",
               prefetch_data, axi_if.m_axi_araddr, axi_if.m_axi_arlen);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst_split();
    int d0 = done_count;
    int w0 = words_seen;
    exp_ar_q.push_back('{addr: 32'h1000, len: 8'd15});
    exp_ar_q.push_back('{addr: 32'h1040, len: 8'd15});
    exp_ar_q.push_back('{addr: 32'h1080, len: 8'd7});
    push_words(32'h1000, 40);
    prefetch_req = 1'b1;
    base_addr = 32'h1000;
    total_nodes = 16'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_bit("start_busy", busy, 1'b1);
    tick();
    check_bit("req_arvalid", axi_if.m_axi_arvalid, 1'b1);
    check_bit("req_grant", prefetch_grant, 1'b1);
    tick();
    check_bit("grant_pulse", prefetch_grant, 1'b0);
    tick();
    check_bit("first_word_valid", prefetch_data_valid, 1'b1);
    wait_run("split", d0, 2000);
    repeat (3) tick();
    vectors++;
    if (exp_ar_q.size() !== 0) begin
      miscompares++;
      $display("FAIL split_ar_left got %0d want 0", exp_ar_q.size());
    end
    vectors++;
    if ((words_seen - w0) !== 40) begin
      miscompares++;
      $display("FAIL split_words got %0d want 40", words_seen - w0);
    end
    vectors++;
    if ((done_count - d0) !== 1) begin
      miscompares++;
      $display("FAIL split_done_pulses got %0d want 1", done_count - d0);
    end
    check_bit("split_busy_end", busy, 1'b0);
    check_bit("split_error", error, 1'b0);
    prefetch_req = 1'b0;
  endtask

  task automatic test_4k_boundary();
    int d0 = done_count;
`ifdef PREFETCH_FETCHER_4K_SPLIT_EN
    exp_ar_q.push_back('{addr: 32'h0FF8, len: 8'd1});
    exp_ar_q.push_back('{addr: 32'h1000, len: 8'd5});
`else
    exp_ar_q.push_back('{addr: 32'h0FF8, len: 8'd7});
`endif
    push_words(32'h0FF8, 8);
    prefetch_req = 1'b1;
    base_addr = 32'h0FF8;
    total_nodes = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("4k", d0, 500);
    vectors++;
    if (exp_ar_q.size() !== 0) begin
      miscompares++;
      $display("FAIL 4k_ar_left got %0d want 0", exp_ar_q.size());
    end
    prefetch_req = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int d0 = done_count;
    int w0 = words_seen;
    exp_ar_q.push_back('{addr: 32'h2000, len: 8'd15});
    push_words(32'h2000, 16);
    ready_toggle = 1'b1;
    prefetch_req = 1'b1;
    base_addr = 32'h2000;
    total_nodes = 16'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("bp", d0, 1000);
    vectors++;
    if ((words_seen - w0) !== 16) begin
      miscompares++;
      $display("FAIL bp_words got %0d want 16", words_seen - w0);
    end
    prefetch_req = 1'b0;
    ready_toggle = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_slverr();
    int d0 = done_count;
    int w0 = words_seen;
    exp_ar_q.push_back('{addr: 32'h3000, len: 8'd15});
    push_words(32'h3000, 16);
    err_beat = beats_sent + 3;
    prefetch_req = 1'b1;
    base_addr = 32'h3000;
    total_nodes = 16'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("err", d0, 1000);
    check_bit("err_set", error, 1'b1);
    repeat (3) tick();
    check_bit("err_sticky", error, 1'b1);
    vectors++;
    if ((words_seen - w0) !== 16) begin
      miscompares++;
      $display("FAIL err_words got %0d want 16", words_seen - w0);
    end
    err_beat = -1;
    prefetch_req = 1'b0;
  endtask

  task automatic test_zero_total();
    int a0 = ar_count;
    int g0 = grant_count;
    prefetch_req = 1'b1;
    base_addr = 32'h5000;
    total_nodes = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_bit("zero_busy", busy, 1'b1);
    check_bit("zero_err_cleared", error, 1'b0);
    check_bit("zero_done_t1", done, 1'b0);
    tick();
    check_bit("zero_done_t2", done, 1'b1);
    check_bit("zero_busy_drop", busy, 1'b0);
    tick();
    check_bit("zero_done_pulse", done, 1'b0);
    repeat (3) tick();
    vectors++;
    if ({ar_count - a0, grant_count - g0} !== 64'd0) begin
      miscompares++;
      $display("FAIL zero_no_ar got ar=%0d grant=%0d want 0 0", ar_count - a0, grant_count - g0);
    end
    prefetch_req = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int d0;
    int b0 = beats_sent;
    int n = 0;
    exp_ar_q.push_back('{addr: 32'h4000, len: 8'd15});
    exp_ar_q.push_back('{addr: 32'h4040, len: 8'd15});
    push_words(32'h4000, 32);
    prefetch_req = 1'b1;
    base_addr = 32'h4000;
    total_nodes = 16'd32;
    start = 1'b1;
    tick();
    start = 1'b0;
    while ((beats_sent - b0) < 5 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL rstmid_timeout got %0d beats want 5", beats_sent - b0);
    end
    rst = 1'b1;
    exp_word_q.delete();
    exp_ar_q.delete();
    tick();
    check_bit("rstmid_busy", busy, 1'b0);
    check_bit("rstmid_arvalid", axi_if.m_axi_arvalid, 1'b0);
    check_bit("rstmid_valid", prefetch_data_valid, 1'b0);
    rst = 1'b0;
    tick();
    d0 = done_count;
    exp_ar_q.push_back('{addr: 32'h4000, len: 8'd15});
    push_words(32'h4000, 16);
    total_nodes = 16'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("refetch", d0, 1000);
    vectors++;
    if (exp_ar_q.size() !== 0) begin
      miscompares++;
      $display("FAIL refetch_ar_left got %0d want 0", exp_ar_q.size());
    end
    prefetch_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    prefetch_req = 1'b0;
    prefetch_data_ready = 1'b1;
    axi_if.m_axi_arready = 1'b1;
    axi_if.m_axi_rvalid  = 1'b0;
    axi_if.m_axi_rdata   = '0;
    axi_if.m_axi_rresp   = 2'b00;
    axi_if.m_axi_rlast   = 1'b0;
    fork
      slave_loop();
      consumer_loop();
      ready_loop();
    join_none
    test_reset();
    test_burst_split();
    test_4k_boundary();
    test_backpressure();
    test_slverr();
    test_zero_total();
    test_reset_mid_run();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
